// File: rtl/battle_pkg.sv
// Shared types and constants for the Battleship turn controller.
// Board geometry, fleet size, FSM state type and guess validity helper.
package battle_pkg;

  localparam int unsigned CELLS      = 28;
  localparam int unsigned SHIP_CELLS = 5;
  localparam int unsigned CNT_W      = $clog2(CELLS + 1);

  typedef enum logic [1:0] {
    SETUP,
    P_TURN,
    C_REQ,
    DONE
  } state_e;

  function automatic logic is_onehot(input logic [CELLS-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      n += 32'(v[i]);
    end
    return n == 1;
  endfunction

endpackage

// File: rtl/cell_popcount.sv
// Combinational population count of a board cell map.
module cell_popcount
  import battle_pkg::*;
(
  input  logic [CELLS-1:0] cells_i,
  output logic [CNT_W-1:0] count_o
);

  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      count_o = count_o + CNT_W'(cells_i[i]);
    end
  end

endmodule

// File: rtl/battle_turn_ctrl.sv
// Battleship match sequencer: SETUP, alternating player/CPU turns, scoring, game over.
// Optional player-turn forfeit timer enabled by defining TURN_TIMEOUT_EN.
module battle_turn_ctrl
  import battle_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2**27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             new_game,
  input  logic [CELLS-1:0] pships,
  input  logic [CELLS-1:0] cships,
  input  logic             guess_valid,
  input  logic [CELLS-1:0] sing_guess,
  input  logic             cpu_ack,
  input  logic [CELLS-1:0] cpu_guess,
  output logic             phase,
  output logic             turn,
  output logic             cpu_req,
  output logic             p_hit,
  output logic             p_miss,
  output logic             c_hit,
  output logic             c_miss,
  output logic             bad_guess,
  output logic [CNT_W-1:0] p_hits,
  output logic [CNT_W-1:0] c_hits,
  output logic             game_over,
  output logic             winner
);

  state_e           state_q;
  logic             phase_q, turn_q, cpu_req_q, game_over_q, winner_q;
  logic             p_hit_q, p_miss_q, c_hit_q, c_miss_q, bad_q;
  logic [CNT_W-1:0] p_hits_q, c_hits_q, p_hits_d, c_hits_d;
  logic [CELLS-1:0] p_used_q, c_used_q;
  logic [CNT_W-1:0] fleet_cnt;
  logic             fleet_ready, p_ok, p_is_hit, c_ok, c_is_hit, p_win, c_win;
  logic             forfeit;

  cell_popcount u_fleet_cnt (
    .cells_i (pships),
    .count_o (fleet_cnt)
  );

  assign fleet_ready = (fleet_cnt == CNT_W'(SHIP_CELLS));

  assign p_ok     = is_onehot(sing_guess) && ((sing_guess & p_used_q) == '0);
  assign p_is_hit = |(sing_guess & cships);
  assign c_ok     = cpu_req_q && is_onehot(cpu_guess) && ((cpu_guess & c_used_q) == '0);
  assign c_is_hit = |(cpu_guess & pships);

  // Saturating increments; win is judged on the post-increment score.
  always_comb begin
    p_hits_d = p_hits_q;
    c_hits_d = c_hits_q;
    if (p_is_hit && (p_hits_q != CNT_W'(SHIP_CELLS))) p_hits_d = p_hits_q + CNT_W'(1);
    if (c_is_hit && (c_hits_q != CNT_W'(SHIP_CELLS))) c_hits_d = c_hits_q + CNT_W'(1);
  end

  assign p_win = (p_hits_d == CNT_W'(SHIP_CELLS));
  assign c_win = (c_hits_d == CNT_W'(SHIP_CELLS));

`ifdef TURN_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] tmr_q;

  assign forfeit = (state_q == P_TURN) && !guess_valid && (tmr_q == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
    end else if (new_game || (state_q != P_TURN) || guess_valid || forfeit) begin
      tmr_q <= '0;
    end else begin
      tmr_q <= tmr_q + TW'(1);
    end
  end
`else
  assign forfeit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SETUP;
      phase_q     <= 1'b0;
      turn_q      <= 1'b0;
      cpu_req_q   <= 1'b0;
      game_over_q <= 1'b0;
      winner_q    <= 1'b0;
      p_hit_q     <= 1'b0;
      p_miss_q    <= 1'b0;
      c_hit_q     <= 1'b0;
      c_miss_q    <= 1'b0;
      bad_q       <= 1'b0;
      p_hits_q    <= '0;
      c_hits_q    <= '0;
      p_used_q    <= '0;
      c_used_q    <= '0;
    end else begin
      p_hit_q  <= 1'b0;
      p_miss_q <= 1'b0;
      c_hit_q  <= 1'b0;
      c_miss_q <= 1'b0;
      bad_q    <= 1'b0;
      if (new_game) begin
        state_q     <= SETUP;
        phase_q     <= 1'b0;
        turn_q      <= 1'b0;
        cpu_req_q   <= 1'b0;
        game_over_q <= 1'b0;
        winner_q    <= 1'b0;
        p_hits_q    <= '0;
        c_hits_q    <= '0;
        p_used_q    <= '0;
        c_used_q    <= '0;
      end else begin
        unique case (state_q)
          SETUP: begin
            if (fleet_ready) begin
              state_q <= P_TURN;
              phase_q <= 1'b1;
              turn_q  <= 1'b0;
            end
          end
          P_TURN: begin
            if (guess_valid) begin
              if (!p_ok) begin
                bad_q <= 1'b1;
              end else begin
                p_used_q <= p_used_q | sing_guess;
                p_hits_q <= p_hits_d;
                p_hit_q  <= p_is_hit;
                p_miss_q <= !p_is_hit;
                if (p_win) begin
                  state_q     <= DONE;
                  game_over_q <= 1'b1;
                  winner_q    <= 1'b0;
                end else begin
                  state_q   <= C_REQ;
                  turn_q    <= 1'b1;
                  cpu_req_q <= 1'b1;
                end
              end
            end else if (forfeit) begin
              state_q   <= C_REQ;
              turn_q    <= 1'b1;
              cpu_req_q <= 1'b1;
            end
          end
          C_REQ: begin
            if (cpu_ack && c_ok) begin
              c_used_q  <= c_used_q | cpu_guess;
              c_hits_q  <= c_hits_d;
              c_hit_q   <= c_is_hit;
              c_miss_q  <= !c_is_hit;
              cpu_req_q <= 1'b0;
              if (c_win) begin
                state_q     <= DONE;
                game_over_q <= 1'b1;
                winner_q    <= 1'b1;
              end else begin
                state_q <= P_TURN;
                turn_q  <= 1'b0;
              end
            end
          end
          DONE: ;
          default: state_q <= SETUP;
        endcase
      end
    end
  end

  assign phase     = phase_q;
  assign turn      = turn_q;
  assign cpu_req   = cpu_req_q;
  assign p_hit     = p_hit_q;
  assign p_miss    = p_miss_q;
  assign c_hit     = c_hit_q;
  assign c_miss    = c_miss_q;
  assign bad_guess = bad_q;
  assign p_hits    = p_hits_q;
  assign c_hits    = c_hits_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;

endmodule

// File: tb/tb_battle_turn_ctrl.sv
// Self-checking bench for battle_turn_ctrl: match-level reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_battle_turn_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        new_game = 1'b0;
  logic [27:0] pships = '0;
  logic [27:0] cships = '0;
  logic        guess_valid = 1'b0;
  logic [27:0] sing_guess = '0;
  logic        cpu_ack = 1'b0;
  logic [27:0] cpu_guess = '0;
  logic        phase, turn, cpu_req, p_hit, p_miss, c_hit, c_miss, bad_guess, game_over, winner;
  logic [4:0]  p_hits, c_hits;

  int n_cmp = 0;
  int n_err = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  battle_turn_ctrl #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .pships(pships), .cships(cships),
    .guess_valid(guess_valid), .sing_guess(sing_guess), .cpu_ack(cpu_ack), .cpu_guess(cpu_guess),
    .phase(phase), .turn(turn), .cpu_req(cpu_req), .p_hit(p_hit), .p_miss(p_miss),
    .c_hit(c_hit), .c_miss(c_miss), .bad_guess(bad_guess), .p_hits(p_hits), .c_hits(c_hits),
    .game_over(game_over), .winner(winner)
  );

  // Match-level model: who is to move, what has been guessed, the score.
  bit        started = 0, cpu_turn = 0, finished = 0, who_won = 0;
  bit        e_ph = 0, e_pm = 0, e_ch = 0, e_cm = 0, e_bad = 0;
  int        p_score = 0, c_score = 0, idle = 0;
  bit [27:0] p_seen = '0, c_seen = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      started = 0; cpu_turn = 0; finished = 0; who_won = 0;
      e_ph = 0; e_pm = 0; e_ch = 0; e_cm = 0; e_bad = 0;
      p_score = 0; c_score = 0; idle = 0; p_seen = '0; c_seen = '0;
    end else begin
      e_ph = 0; e_pm = 0; e_ch = 0; e_cm = 0; e_bad = 0;
      if (new_game) begin
        started = 0; cpu_turn = 0; finished = 0; who_won = 0;
        p_score = 0; c_score = 0; idle = 0; p_seen = '0; c_seen = '0;
      end else if (!started) begin
        if ($countones(pships) == 5) started = 1;
      end else if (finished) begin
      end else if (!cpu_turn) begin
        if (guess_valid) begin
          idle = 0;
          if (!$onehot(sing_guess) || ((sing_guess & p_seen) != 0)) e_bad = 1;
          else begin
            p_seen = p_seen | sing_guess;
            if ((sing_guess & cships) != 0) begin e_ph = 1; p_score++; end
            else e_pm = 1;
            if (p_score == 5) begin finished = 1; who_won = 0; end
            else cpu_turn = 1;
          end
        end else begin
`ifdef TURN_TIMEOUT_EN
          idle++;
          if (idle == 16) begin idle = 0; cpu_turn = 1; end
`endif
        end
      end else begin
        idle = 0;
        if (cpu_ack && $onehot(cpu_guess) && ((cpu_guess & c_seen) == 0)) begin
          c_seen = c_seen | cpu_guess;
          if ((cpu_guess & pships) != 0) begin e_ch = 1; c_score++; end
          else e_cm = 1;
          if (c_score == 5) begin finished = 1; who_won = 1; end
          else cpu_turn = 0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      check("m_phase", 32'(phase), 32'(started));
      check("m_turn", 32'(turn), 32'(cpu_turn));
      check("m_cpu_req", 32'(cpu_req), 32'(started && cpu_turn && !finished));
      check("m_p_hit", 32'(p_hit), 32'(e_ph));
      check("m_p_miss", 32'(p_miss), 32'(e_pm));
      check("m_c_hit", 32'(c_hit), 32'(e_ch));
      check("m_c_miss", 32'(c_miss), 32'(e_cm));
      check("m_bad", 32'(bad_guess), 32'(e_bad));
      check("m_p_hits", 32'(p_hits), 32'(p_score));
      check("m_c_hits", 32'(c_hits), 32'(c_score));
      check("m_game_over", 32'(game_over), 32'(finished));
      check("m_winner", 32'(winner), 32'(who_won));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pguess(input logic [27:0] g);
    sing_guess = g; guess_valid = 1'b1;
    cyc();
    guess_valid = 1'b0;
  endtask

  task automatic cguess(input logic [27:0] g);
    cpu_guess = g; cpu_ack = 1'b1;
    cyc();
    cpu_ack = 1'b0;
  endtask

  initial begin
    cships = 28'hAA8;  // bits 3,5,7,9,11
    pships = 28'hF;    // four cells only
    repeat (3) cyc();
    run = 1'b1;
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_p_hits", 32'(p_hits), 32'd0);
    check("rst_cpu_req", 32'(cpu_req), 32'd0);
    rst = 1'b0;
    repeat (3) cyc();
    check("setup_4cells", 32'(phase), 32'd0);
    pships = 28'h1F;   // bits 0..4
    cyc();
    check("setup_5cells", 32'(phase), 32'd1);

    pguess(28'h8);
    check("p_first_hit", 32'(p_hit), 32'd1);
    check("p_hits_1", 32'(p_hits), 32'd1);
    check("req_up", 32'(cpu_req), 32'd1);

    cguess(28'h3);
    check("c_bad_ack_req", 32'(cpu_req), 32'd1);
    cguess(28'h1);
    check("c_first_hit", 32'(c_hit), 32'd1);
    check("c_hits_1", 32'(c_hits), 32'd1);
    check("req_down", 32'(cpu_req), 32'd0);

    cguess(28'h8);     // no request outstanding
    pguess(28'h8);
    check("p_repeat_bad", 32'(bad_guess), 32'd1);
    check("p_repeat_hits", 32'(p_hits), 32'd1);
    pguess(28'h30);
    check("p_multi_bad", 32'(bad_guess), 32'd1);
    pguess(28'h20);
    cguess(28'h1);     // repeated CPU guess, discarded
    cguess(28'h100);
    check("c_miss", 32'(c_miss), 32'd1);
    pguess(28'h80);
    cguess(28'h2);
    pguess(28'h200);
    cguess(28'h400);
    pguess(28'h1);
    check("p_miss", 32'(p_miss), 32'd1);
    cguess(28'h4);
    check("c_hits_3", 32'(c_hits), 32'd3);
    pguess(28'h800);
    check("p_win_over", 32'(game_over), 32'd1);
    check("p_win_who", 32'(winner), 32'd0);
    check("p_hits_5", 32'(p_hits), 32'd5);
    pguess(28'h1000);
    cguess(28'h10);
    cyc();
    check("done_p_frozen", 32'(p_hits), 32'd5);
    check("done_c_frozen", 32'(c_hits), 32'd3);

    new_game = 1'b1; cyc(); new_game = 1'b0;
    check("ng_phase", 32'(phase), 32'd0);
    check("ng_over", 32'(game_over), 32'd0);
    check("ng_hits", 32'(p_hits), 32'd0);
    cyc();
    pguess(28'h8);
    check("pre_rst_req", 32'(cpu_req), 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_req", 32'(cpu_req), 32'd0);
    check("async_rst_phase", 32'(phase), 32'd0);
    check("async_rst_hits", 32'(p_hits), 32'd0);
    cyc();
    rst = 1'b0;
    cyc();
    check("re_enter_game", 32'(phase), 32'd1);
    new_game = 1'b1; sing_guess = 28'h8; guess_valid = 1'b1;
    cyc();
    new_game = 1'b0; guess_valid = 1'b0;
    check("ng_beats_guess_pulse", 32'(p_hit), 32'd0);
    check("ng_beats_guess_phase", 32'(phase), 32'd0);
    cyc();
    check("ready_again", 32'(phase), 32'd1);
`ifdef TURN_TIMEOUT_EN
    repeat (15) cyc();
    check("to_before", 32'(turn), 32'd0);
    cyc();
    check("to_forfeit", 32'(turn), 32'd1);
    check("to_no_score", 32'(p_hits), 32'd0);
`endif
    repeat (2) cyc();
    run = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
